// File: rtl/ysyx_22041207_read_arb_pkg.sv
// Shared definitions for the two-port read arbiter: FSM encoding, requester
// IDs and the default size code.
package ysyx_22041207_read_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    localparam logic [7:0] SIZE_DEFAULT = 8'b00001111;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return (id == REQ_LSU) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ysyx_22041207_rr_pick2.sv
// Combinational two-way round-robin select: a lone request wins outright,
// a tie goes to the requester that was not served last.
module ysyx_22041207_rr_pick2
    import ysyx_22041207_read_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_g,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_g == REQ_IF) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_22041207_read_arb.sv
// Shares one read channel between instruction fetch (port 0) and the LSU
// (port 1); one transaction in flight, response routed back to its owner.
module ysyx_22041207_read_arb
    import ysyx_22041207_read_arb_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [1:0]    m_r_valid,
    output logic [1:0]    m_r_ready,
    input  logic [AW-1:0] m0_r_addr,
    input  logic [AW-1:0] m1_r_addr,
    input  logic [7:0]    m0_r_size,
    input  logic [7:0]    m1_r_size,
    output logic [1:0]    m_data_valid,
    input  logic [1:0]    m_data_ready,
    output logic [DW-1:0] m_data,

    output logic          rx_r_valid_i,
    input  logic          rx_r_ready_o,
    output logic [AW-1:0] rx_r_addr_i,
    output logic [7:0]    rx_r_size_i,
    input  logic          rx_data_valid,
    output logic          rx_data_ready,
    input  logic [DW-1:0] rx_data_read_o
);

    arb_state_t    state;
    logic          last_g;
    logic          cur_g;
    logic [AW-1:0] addr_q;
    logic [7:0]    size_q;
    logic [DW-1:0] data_q;
    logic [1:0]    grant;
    logic          grant_id;

    ysyx_22041207_rr_pick2 u_pick (
        .req    (m_r_valid),
        .last_g (last_g),
        .grant  (grant)
    );

    assign grant_id = grant[1];

    // last_g only advances once data is captured, so an abandoned
    // transaction does not cost its requester its turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_g <= REQ_LSU;
            cur_g  <= REQ_IF;
            addr_q <= '0;
            size_q <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_r_valid) begin
                        cur_g  <= grant_id;
                        addr_q <= (grant_id == REQ_LSU) ? m1_r_addr : m0_r_addr;
                        size_q <= (grant_id == REQ_LSU) ? m1_r_size : m0_r_size;
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (rx_r_ready_o) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (rx_data_valid) begin
                        data_q <= rx_data_read_o;
                        last_g <= cur_g;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (m_data_ready[cur_g]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accept is the only output allowed to follow m_r_valid in the same cycle.
    assign m_r_ready     = (state == IDLE) ? grant : 2'b00;
    assign rx_r_valid_i  = (state == ADDR);
    assign rx_data_ready = (state == DATA);
    assign m_data_valid  = (state == RESP) ? id_to_onehot(cur_g) : 2'b00;
    assign rx_r_addr_i   = addr_q;
    assign rx_r_size_i   = size_q;
    assign m_data        = data_q;

endmodule
